tone_seq_synth: RTL and testbench
=================================

// Module: tone_seq_synth
// PURPOSE
//  Parametrised multi-voice square-wave synthesiser and step sequencer for the
//  VGA demo top level. Voice dividers advance once per scanline (line_tick from
//  the hvsync generator), the sequencer advances every STEP_FRAMES frames, a
//  per-step decay envelope sets loudness, and a first-order sigma-delta mixer
//  drives the 1-bit audio pin (uio_out[7]). The note table is host-writable.
// PARAMETERS
//  NVOICES     2    number of independent square-wave voices (>=1)
//  DIV_W       9    divider/period width in scanlines
//  STEPS       8    sequence length in steps (>=2)
//  STEP_FRAMES 128  frames per step (>=1)
//  ENV_W       5    envelope width; ENV_MAX = 2^ENV_W-1
//  (derived) AW = $clog2(STEPS*NVOICES), SW = $clog2(STEPS), M = ENV_W+$clog2(NVOICES)
// PORTS
//  clk         in   1        system (pixel) clock
//  rst_n       in   1        asynchronous active-low reset
//  line_tick   in   1        1-cycle pulse per scanline (hpos==0)
//  frame_tick  in   1        1-cycle pulse per frame (hpos==0 && vpos==0)
//  run         in   1        1 = sequencer playing, 0 = stopped/silent
//  seq_we      in   1        note table write strobe
//  seq_addr    in   AW       table index = step*NVOICES + voice
//  seq_data    in   DIV_W    half-period in scanlines minus 1; 0 = rest
//  voice_out   out  NVOICES  raw square wave per voice
//  sound       out  1        sigma-delta mixed audio bit
//  step_idx    out  SW       current sequence step
//  env_level   out  ENV_W    current envelope value
//  step_strobe out  1        1-cycle pulse when step advances
// BEHAVIOUR
//  Reset (async assert, sync-released use): table all 0, all counters 0, all outputs 0.
//  Table: STEPS*NVOICES regs of DIV_W. seq_we with seq_addr < STEPS*NVOICES writes at
//   posedge; out-of-range addr ignored. Write visible from next cycle; a same-cycle
//   read of that entry sees the old value. Writes accepted regardless of run.
//  Voice v: period P = table[step_idx*NVOICES+v]. P==0: ctr<=0, voice_out[v]<=0.
//   Else on line_tick: ctr>=P -> ctr<=0, voice_out[v] toggles; else ctr<=ctr+1.
//   Half-period = P+1 lines. Period change does not reset ctr (ctr>=P catches shrink).
//  Sequencer (run=1): on frame_tick, frame_cnt==STEP_FRAMES-1 -> frame_cnt<=0,
//   step_idx <= (step_idx==STEPS-1)?0:step_idx+1, env<=ENV_MAX, step_strobe=1 next
//   cycle; else frame_cnt+1 and env <= (env==0)?0:env-1 (saturating decay).
//  run low: step_idx, frame_cnt, env, all ctr and voice_out forced 0 next cycle.
//   run 0->1 edge (run & ~run_q): env<=ENV_MAX; step 0 plays from that cycle.
//  Simultaneous line_tick+frame_tick: both processed; dividers use pre-advance step.
//  Mixer, every clk: mix = sum_v (voice_out[v] ? env : 0), width M; {sound,acc} <=
//   acc + mix (acc M bits, sound = carry). Pulse density = mix/2^M. Registered output,
//   1 cycle latency from voice_out/env. acc cleared while run=0.
//  No combinational path from inputs to outputs.
// TESTING
//  1 Reset: rst_n=0 mid-run, async -> all outputs 0 without clk edge; table reads 0.
//  2 Divider: table[0]=3, run=1, 20 line_ticks -> voice_out[0] toggles every 4 ticks.
//  3 Rest/voices: table[1]=0, table[0]=5 -> voice_out[1] stays 0, voice_out[0] 6-line halves.
//  4 Step/wrap: STEP_FRAMES=4, STEPS=8 -> step_strobe after 4th frame_tick, step 7->0 wrap.
//  5 Envelope: run rise -> env=31, decrements per frame_tick, holds 0; reload on step.
//  6 Mixer: NVOICES=2, voice0 high, env=31 fixed -> 31 sound=1 per 64 clks exactly.

Source files
------------

// File: rtl/tone_seq_synth.sv
// tone_seq_synth: multi-voice square-wave synth with step sequencer,
// per-step decay envelope and first-order sigma-delta 1-bit mixer.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   line_tick, frame_tick scanline / frame pulses from the video timing
//   run                   1 = play sequence, 0 = stopped and silent
//   seq_we/addr/data      note table write port (addr = step*NVOICES+voice)
//   voice_out             raw square wave per voice
//   sound                 sigma-delta audio bit
//   step_idx, env_level   current sequencer step and envelope value
//   step_strobe           one-cycle pulse after the step advances
module tone_seq_synth #(
    parameter  int NVOICES     = 2,
    parameter  int DIV_W       = 9,
    parameter  int STEPS       = 8,
    parameter  int STEP_FRAMES = 128,
    parameter  int ENV_W       = 5,
    localparam int DEPTH       = STEPS * NVOICES,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SW          = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_tick,
    input  logic               frame_tick,
    input  logic               run,
    input  logic               seq_we,
    input  logic [AW-1:0]      seq_addr,
    input  logic [DIV_W-1:0]   seq_data,
    output logic [NVOICES-1:0] voice_out,
    output logic               sound,
    output logic [SW-1:0]      step_idx,
    output logic [ENV_W-1:0]   env_level,
    output logic               step_strobe
);

    localparam int NVB = (NVOICES > 1) ? $clog2(NVOICES) : 0;
    localparam int M   = ENV_W + NVB;
    localparam int FW  = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    localparam logic [ENV_W-1:0] ENV_MAX   = '1;
    localparam logic [AW:0]      DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [FW-1:0]    FRAME_END = FW'(STEP_FRAMES - 1);
    localparam logic [SW-1:0]    STEP_END  = SW'(STEPS - 1);

    logic [DIV_W-1:0] tbl    [DEPTH];
    logic [DIV_W-1:0] period [NVOICES];
    logic [DIV_W-1:0] ctr    [NVOICES];

    logic          run_q;
    logic          run_rise;
    logic [FW-1:0] frame_cnt;
    logic          frame_wrap;
    logic          addr_ok;

    logic [M-1:0]  mix;
    logic [M-1:0]  acc;

    assign run_rise   = run & ~run_q;
    assign frame_wrap = (frame_cnt == FRAME_END);
    assign addr_ok    = ({1'b0, seq_addr} < DEPTH_L);

    // Note table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (seq_we && addr_ok) begin
            tbl[seq_addr] <= seq_data;
        end
    end

    // Current-step periods; reads the pre-write, pre-advance values
    always_comb begin
        for (int v = 0; v < NVOICES; v++) begin
            period[v] = tbl[AW'(int'(step_idx) * NVOICES + v)];
        end
    end

    // Voice dividers; ctr >= P also covers a period that shrank mid-count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voice_out <= '0;
            for (int v = 0; v < NVOICES; v++) begin
                ctr[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NVOICES; v++) begin
                if (!run || period[v] == '0) begin
                    ctr[v]       <= '0;
                    voice_out[v] <= 1'b0;
                end else if (line_tick) begin
                    if (ctr[v] >= period[v]) begin
                        ctr[v]       <= '0;
                        voice_out[v] <= ~voice_out[v];
                    end else begin
                        ctr[v] <= ctr[v] + DIV_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run;
        end
    end

    // Sequencer and envelope
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_idx    <= '0;
            frame_cnt   <= '0;
            env_level   <= '0;
            step_strobe <= 1'b0;
        end else if (!run) begin
            step_idx    <= '0;
            frame_cnt   <= '0;
            env_level   <= '0;
            step_strobe <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            if (frame_tick) begin
                if (frame_wrap) begin
                    frame_cnt   <= '0;
                    step_idx    <= (step_idx == STEP_END) ?
                                   '0 : step_idx + SW'(1);
                    env_level   <= ENV_MAX;
                    step_strobe <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                    env_level <= (env_level == '0) ?
                                 '0 : env_level - ENV_W'(1);
                end
            end
            // Starting playback always begins at full loudness
            if (run_rise) begin
                env_level <= ENV_MAX;
            end
        end
    end

    // Mixer: sum of gated envelope per active voice
    always_comb begin
        mix = '0;
        for (int v = 0; v < NVOICES; v++) begin
            mix = mix + (voice_out[v] ? M'(env_level) : M'(0));
        end
    end

    // Sigma-delta: carry out of the accumulator is the pulse stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            sound <= 1'b0;
        end else if (!run) begin
            acc   <= '0;
            sound <= 1'b0;
        end else begin
            {sound, acc} <= {1'b0, acc} + {1'b0, mix};
        end
    end

endmodule

// File: tb/tb_tone_seq_synth.sv
// tb_tone_seq_synth: scoreboard bench for tone_seq_synth.
// Two instances share stimulus: short steps (4 frames) and long (128).
module tb_tone_seq_synth;

    localparam int NV = 2;
    localparam int DW = 9;
    localparam int ST = 8;
    localparam int EW = 5;
    localparam int AW = 4;
    localparam int SW = 3;

    logic          clk;
    logic          rst_n;
    logic          line_tick;
    logic          frame_tick;
    logic          run;
    logic          seq_we;
    logic [AW-1:0] seq_addr;
    logic [DW-1:0] seq_data;

    logic [NV-1:0] voice_out;
    logic          sound;
    logic [SW-1:0] step_idx;
    logic [EW-1:0] env_level;
    logic          step_strobe;

    logic [NV-1:0] voice_out2;
    logic          sound2;
    logic [SW-1:0] step_idx2;
    logic [EW-1:0] env_level2;
    logic          step_strobe2;

    tone_seq_synth #(
        .NVOICES(NV), .DIV_W(DW), .STEPS(ST),
        .STEP_FRAMES(4), .ENV_W(EW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .line_tick(line_tick), .frame_tick(frame_tick),
        .run(run), .seq_we(seq_we),
        .seq_addr(seq_addr), .seq_data(seq_data),
        .voice_out(voice_out), .sound(sound),
        .step_idx(step_idx), .env_level(env_level),
        .step_strobe(step_strobe)
    );

    tone_seq_synth #(
        .NVOICES(NV), .DIV_W(DW), .STEPS(ST),
        .STEP_FRAMES(128), .ENV_W(EW)
    ) u_long (
        .clk(clk), .rst_n(rst_n),
        .line_tick(line_tick), .frame_tick(frame_tick),
        .run(run), .seq_we(seq_we),
        .seq_addr(seq_addr), .seq_data(seq_data),
        .voice_out(voice_out2), .sound(sound2),
        .step_idx(step_idx2), .env_level(env_level2),
        .step_strobe(step_strobe2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam int S_V0   = 0;
    localparam int S_V1   = 1;
    localparam int S_STEP = 2;
    localparam int S_ENV  = 3;
    localparam int S_STB  = 4;
    localparam int S_SND  = 5;
    localparam int S_ENV2 = 6;
    localparam int S_STP2 = 7;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            S_V0:    return int'(voice_out[0]);
            S_V1:    return int'(voice_out[1]);
            S_STEP:  return int'(step_idx);
            S_ENV:   return int'(env_level);
            S_STB:   return int'(step_strobe);
            S_SND:   return int'(sound);
            S_ENV2:  return int'(env_level2);
            S_STP2:  return int'(step_idx2);
            default: return -1;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.tag, observe(x.sel), x.exp);
        end
    endtask

    task automatic push_all_zero(input string tag);
        push({tag, "_v0"}, S_V0, 0);
        push({tag, "_v1"}, S_V1, 0);
        push({tag, "_step"}, S_STEP, 0);
        push({tag, "_env"}, S_ENV, 0);
        push({tag, "_stb"}, S_STB, 0);
        push({tag, "_snd"}, S_SND, 0);
        push({tag, "_env2"}, S_ENV2, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic line();
        line_tick = 1'b1;
        cyc();
        line_tick = 1'b0;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        seq_we   = 1'b1;
        seq_addr = AW'(a);
        seq_data = DW'(d);
        cyc();
        seq_we   = 1'b0;
    endtask

    task automatic set_run(input logic b);
        run = b;
        cyc();
    endtask

    task automatic count_sound(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            n += int'(sound);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        line_tick  = 1'b0;
        frame_tick = 1'b0;
        run        = 1'b0;
        seq_we     = 1'b0;
        seq_addr   = '0;
        seq_data   = '0;

        #12;
        push_all_zero("rst");
        drain();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Divider: half period of 4 lines
        wr(0, 3);
        wr(1, 0);
        push("t2_env_rise", S_ENV, 31);
        push("t2_env2_rise", S_ENV2, 31);
        set_run(1'b1);
        drain();
        for (int i = 1; i <= 20; i++) begin
            push($sformatf("t2_v0_%0d", i), S_V0, (i / 4) % 2);
            push($sformatf("t2_v1_%0d", i), S_V1, 0);
            line();
            drain();
        end

        // Async reset mid-run, no clock edge in between
        #3;
        rst_n = 1'b0;
        #1;
        push_all_zero("arst");
        drain();
        cyc();
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            push($sformatf("clr_v0_%0d", i), S_V0, 0);
            line();
            drain();
        end

        // Rest voice plus 6-line halves
        set_run(1'b0);
        wr(0, 5);
        set_run(1'b1);
        for (int i = 1; i <= 18; i++) begin
            push($sformatf("t3_v0_%0d", i), S_V0, (i / 6) % 2);
            push($sformatf("t3_v1_%0d", i), S_V1, 0);
            line();
            drain();
        end

        // Steps, wrap, envelope decay and reload
        set_run(1'b0);
        push("t4_env", S_ENV, 31);
        push("t4_step", S_STEP, 0);
        set_run(1'b1);
        drain();
        for (int k = 1; k <= 40; k++) begin
            push($sformatf("t4_step_%0d", k), S_STEP, (k / 4) % 8);
            push($sformatf("t4_env_%0d", k), S_ENV,
                 (k % 4 == 0) ? 31 : 31 - (k % 4));
            push($sformatf("t4_stb_%0d", k), S_STB,
                 (k % 4 == 0) ? 1 : 0);
            push($sformatf("t5_env2_%0d", k), S_ENV2,
                 (k < 31) ? 31 - k : 0);
            push($sformatf("t5_stp2_%0d", k), S_STP2, 0);
            frame();
            drain();
            if (k % 4 == 0) begin
                push($sformatf("t4_stb_off_%0d", k), S_STB, 0);
                cyc();
                drain();
            end
        end

        // Mixer: one voice at env 31 -> 31 of 64
        set_run(1'b0);
        wr(0, 1);
        set_run(1'b1);
        line();
        line();
        push("t6_v0", S_V0, 1);
        push("t6_v1", S_V1, 0);
        push("t6_env", S_ENV, 31);
        drain();
        repeat (3) cyc();
        count_sound(n);
        chk("mix_one", n, 31);

        // Both voices high -> 62 of 64
        set_run(1'b0);
        wr(1, 1);
        set_run(1'b1);
        line();
        line();
        push("t6b_v0", S_V0, 1);
        push("t6b_v1", S_V1, 1);
        drain();
        repeat (3) cyc();
        count_sound(n);
        chk("mix_two", n, 62);

        // Stopped -> silent
        set_run(1'b0);
        count_sound(n);
        chk("mix_stop", n, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
